adc_cfg_seq: RTL
================

Name: adc_cfg_seq

Overview:
Configuration sequencer that sits directly upstream of the ADC serial-config writer. It accepts gain/offset update requests from the control logic and latches them. It drives the writer's ENABLE/GAIN/OFFSET inputs through a load → shift → settle sequence and reports completion. It also performs an automatic power-up configuration with default values.

Parameters:
FRAME_LEN, 54, cycles ENABLE is held high per frame (52 frame bits + 2 flush cycles)
SETTLE_CYCLES, 16, cycles ENABLE is held low after a frame before DONE (ADC register settling)
DEF_GAIN, 6'd20, gain applied by power-up auto-configuration
DEF_OFFSET, 9'd256, offset applied by power-up auto-configuration
OFFSET_MAX, 9'd480, largest legal offset; larger requests are clamped
AUTO_INIT, 1, 1 = run one configuration automatically after reset

Ports:
CLK  in  1  system clock; the downstream serializer runs on the same edge
RST  in  1  synchronous, active-high reset
REQ  in  1  one-cycle request strobe; samples GAIN_IN/OFFSET_IN
GAIN_IN  in  6  requested gain code
OFFSET_IN  in  9  requested offset code
ENABLE  out  1  to serializer; low = preload/idle, high = shift
GAIN  out  6  to serializer; held stable whenever ENABLE is high
OFFSET  out  9  to serializer; held stable whenever ENABLE is high
BUSY  out  1  high from sequence start until the DONE cycle inclusive
DONE  out  1  one-cycle pulse when a sequence completes
CLAMPED  out  1  valid with DONE; 1 if the applied offset was clamped
PENDING  out  1  a request is queued behind the running sequence

Behaviour:
- Reset (RST=1 at a CLK edge): ENABLE=0, GAIN=DEF_GAIN, OFFSET=DEF_OFFSET, BUSY=0, DONE=0, CLAMPED=0, PENDING=0, pending slot cleared, counters=0, state=IDLE. The downstream frame is aborted because ENABLE returns low.
- First cycle after reset: if AUTO_INIT=1, an internal request with DEF_GAIN/DEF_OFFSET enters LOAD as though REQ had been strobed.
- States: IDLE, LOAD, SHIFT, SETTLE, FIN.
- IDLE: ENABLE=0, BUSY=0. REQ=1 latches GAIN_IN and min(OFFSET_IN, OFFSET_MAX) onto GAIN/OFFSET, records the clamp flag, and moves to LOAD.
- LOAD: exactly 1 cycle, ENABLE=0, so the serializer preloads the new values. BUSY=1. Next state is SHIFT.
- SHIFT: ENABLE=1 for exactly FRAME_LEN consecutive cycles, counted by an internal counter from 0 to FRAME_LEN-1. GAIN/OFFSET must not change. Next state is SETTLE.
- SETTLE: ENABLE=0 for SETTLE_CYCLES cycles. A SETTLE_CYCLES value of 0 skips straight to FIN.
- FIN: 1 cycle. DONE=1, CLAMPED is valid, BUSY=1.
  - If PENDING=1: copy the pending slot to GAIN/OFFSET, clear PENDING, go to LOAD.
  - Otherwise: go to IDLE.
- Overall latency, REQ in IDLE to DONE: 1 (latch) + 1 + FRAME_LEN + SETTLE_CYCLES cycles. With defaults, DONE is asserted 72 cycles after REQ.
- REQ while BUSY (any state LOAD..FIN): values are clamped and written to the single-entry pending slot, and PENDING is set.
  - The latest request overwrites an older pending one (last-wins, no error).
  - The running frame is never disturbed.
- REQ in the FIN cycle: treated as a pending request. It is consumed by the LOAD entered from FIN in that same transition; that LOAD uses the REQ values even if the slot held older ones.
- Offset clamp: unsigned comparison. OFFSET_IN > OFFSET_MAX yields OFFSET_MAX. GAIN is passed unchanged (full 6-bit range is legal).
- ENABLE is registered and never glitches. It is high only in SHIFT.
- RST mid-SHIFT: ENABLE drops on the next edge, all requests including PENDING are discarded, and no DONE is issued. Auto-init reruns if enabled.

Test Plan:
- Reset with AUTO_INIT=1, no REQ -> ENABLE low for 2 cycles then high for 54 cycles with GAIN=20, OFFSET=256; DONE pulses once 72 cycles after reset release; CLAMPED=0; BUSY falls after DONE.
- In IDLE, REQ with GAIN_IN=6'h2A, OFFSET_IN=9'd100 -> GAIN=6'h2A, OFFSET=100 from the next cycle; ENABLE high for exactly 54 cycles; DONE 72 cycles after REQ.
- REQ with OFFSET_IN=9'd511 -> OFFSET=480; CLAMPED=1 in the DONE cycle.
- During SHIFT, REQ (gain 1, offset 10) then REQ (gain 2, offset 20) -> PENDING=1; first frame values unchanged; after the first DONE a second sequence runs with gain 2, offset 20; two DONE pulses total.
- REQ (gain 5, offset 50) coincident with DONE -> next LOAD uses gain 5, offset 50 with no IDLE cycle in between; BUSY stays high.
- RST asserted at SHIFT cycle 20 with PENDING=1 -> ENABLE=0, PENDING=0 on the next edge; no DONE for the aborted frame; the auto-init frame then runs with default values.

Source files
------------

// File: rtl/adc_cfg_seq.sv
// Configuration sequencer feeding the ADC serial-config writer: latches gain/offset
// requests, runs load -> shift -> settle frames and queues one request behind a busy frame.
module adc_cfg_seq #(
  parameter int          FRAME_LEN     = 54,
  parameter int          SETTLE_CYCLES = 16,
  parameter logic [5:0]  DEF_GAIN      = 6'd20,
  parameter logic [8:0]  DEF_OFFSET    = 9'd256,
  parameter logic [8:0]  OFFSET_MAX    = 9'd480,
  parameter bit          AUTO_INIT     = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic [5:0] GAIN_IN,
  input  logic [8:0] OFFSET_IN,
  output logic       ENABLE,
  output logic [5:0] GAIN,
  output logic [8:0] OFFSET,
  output logic       BUSY,
  output logic       DONE,
  output logic       CLAMPED,
  output logic       PENDING
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, SETTLE, FIN} state_t;

  localparam int CW = 16;
  localparam logic [CW-1:0] SHIFT_LAST  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [8:0]    DEF_OFF_CL  = (DEF_OFFSET > OFFSET_MAX) ? OFFSET_MAX : DEF_OFFSET;
  localparam logic          DEF_CLAMP   = (DEF_OFFSET > OFFSET_MAX);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [5:0]     gain_nxt, pend_gain, pend_gain_nxt;
  logic [8:0]     offset_nxt, pend_offset, pend_offset_nxt;
  logic           clamp, clamp_nxt, pend_clamp, pend_clamp_nxt;
  logic           pending_nxt, auto_req, auto_req_nxt, enable_nxt;
  logic [8:0]     req_offset;
  logic           req_clamp;

  assign req_clamp  = (OFFSET_IN > OFFSET_MAX);
  assign req_offset = req_clamp ? OFFSET_MAX : OFFSET_IN;

  assign BUSY    = (state != IDLE);
  assign DONE    = (state == FIN);
  assign CLAMPED = DONE & clamp;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      ENABLE      <= 1'b0;
      GAIN        <= DEF_GAIN;
      OFFSET      <= DEF_OFFSET;
      clamp       <= 1'b0;
      pend_gain   <= '0;
      pend_offset <= '0;
      pend_clamp  <= 1'b0;
      PENDING     <= 1'b0;
      auto_req    <= AUTO_INIT;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ENABLE      <= enable_nxt;
      GAIN        <= gain_nxt;
      OFFSET      <= offset_nxt;
      clamp       <= clamp_nxt;
      pend_gain   <= pend_gain_nxt;
      pend_offset <= pend_offset_nxt;
      pend_clamp  <= pend_clamp_nxt;
      PENDING     <= pending_nxt;
      auto_req    <= auto_req_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    gain_nxt        = GAIN;
    offset_nxt      = OFFSET;
    clamp_nxt       = clamp;
    pend_gain_nxt   = pend_gain;
    pend_offset_nxt = pend_offset;
    pend_clamp_nxt  = pend_clamp;
    pending_nxt     = PENDING;
    auto_req_nxt    = auto_req;

    // Requests arriving mid-sequence go to the single pending slot, last one wins.
    if (REQ && (state inside {LOAD, SHIFT, SETTLE})) begin
      pend_gain_nxt   = GAIN_IN;
      pend_offset_nxt = req_offset;
      pend_clamp_nxt  = req_clamp;
      pending_nxt     = 1'b1;
    end

    case (state)
      IDLE: begin
        if (auto_req) begin
          gain_nxt     = DEF_GAIN;
          offset_nxt   = DEF_OFF_CL;
          clamp_nxt    = DEF_CLAMP;
          auto_req_nxt = 1'b0;
          state_nxt    = LOAD;
          if (REQ) begin
            pend_gain_nxt   = GAIN_IN;
            pend_offset_nxt = req_offset;
            pend_clamp_nxt  = req_clamp;
            pending_nxt     = 1'b1;
          end
        end else if (REQ) begin
          gain_nxt   = GAIN_IN;
          offset_nxt = req_offset;
          clamp_nxt  = req_clamp;
          state_nxt  = LOAD;
        end
      end
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (SETTLE_CYCLES == 0) ? FIN : SETTLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = FIN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FIN: begin
        // A request in this very cycle supersedes whatever the slot holds.
        if (REQ) begin
          gain_nxt    = GAIN_IN;
          offset_nxt  = req_offset;
          clamp_nxt   = req_clamp;
          pending_nxt = 1'b0;
          state_nxt   = LOAD;
        end else if (PENDING) begin
          gain_nxt    = pend_gain;
          offset_nxt  = pend_offset;
          clamp_nxt   = pend_clamp;
          pending_nxt = 1'b0;
          state_nxt   = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    enable_nxt = (state_nxt == SHIFT);
  end

endmodule
